// File: rtl/mpc_pkg.sv
// Shared defaults and FSM state type for the port packet forwarder.
package mpc_pkg;

    localparam int PORTNUM = 16;
    localparam int DATAW   = 32;
    localparam int LENW    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/port_word_mux.sv
// Selects the head word and not-empty flag of the granted input port.
module port_word_mux #(
    parameter int PORTNUM = mpc_pkg::PORTNUM,
    parameter int DATAW   = mpc_pkg::DATAW
) (
    input  logic [$clog2(PORTNUM)-1:0] i_sel,
    input  logic [PORTNUM-1:0]         i_valid,
    input  logic [PORTNUM*DATAW-1:0]   i_data,
    output logic                       o_valid,
    output logic [DATAW-1:0]           o_data
);

    // Pure selection by port index.
    always_comb begin
        o_valid = i_valid[i_sel];
        o_data  = i_data[i_sel*DATAW +: DATAW];
    end

endmodule

// File: rtl/port_pkt_forwarder.sv
// Forwards one length-delimited packet from the granted port FIFO to a
// single registered output stage, reporting end-of-packet and errors.
module port_pkt_forwarder #(
    parameter int PORTNUM = mpc_pkg::PORTNUM,
    parameter int DATAW   = mpc_pkg::DATAW,
    parameter int LENW    = mpc_pkg::LENW
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_en,
    input  logic [$clog2(PORTNUM)-1:0] i_sel,
    input  logic [PORTNUM-1:0]         i_valid,
    input  logic [PORTNUM*DATAW-1:0]   i_data,
    output logic [PORTNUM-1:0]         o_pop,
    output logic                       o_valid,
    output logic [DATAW-1:0]           o_data,
    output logic                       o_sop,
    output logic                       o_last,
    input  logic                       i_ready,
    output logic                       o_eop,
    output logic                       o_err
);

    import mpc_pkg::*;

    localparam int SELW = $clog2(PORTNUM);

    fsm_state_t       state_q, state_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic [LENW-1:0]  rem_q, rem_d;
    logic             valid_q, valid_d;
    logic [DATAW-1:0] data_q, data_d;
    logic             sop_q, sop_d;
    logic             last_q, last_d;

    logic             mux_valid;
    logic [DATAW-1:0] mux_data;
    logic             active;
    logic             pop;
    logic             is_last;
    logic [LENW-1:0]  len_eff;

    port_word_mux #(
        .PORTNUM (PORTNUM),
        .DATAW   (DATAW)
    ) u_mux (
        .i_sel   (sel_q),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_valid (mux_valid),
        .o_data  (mux_data)
    );

    // Pop qualification and last-word detection; zero length counts as one word.
    always_comb begin
        active  = (state_q != ST_IDLE);
        pop     = active && i_en && mux_valid && (!valid_q || i_ready);
        len_eff = (mux_data[LENW-1:0] == '0) ? LENW'(1) : mux_data[LENW-1:0];
        is_last = (state_q == ST_HDR) ? (len_eff == LENW'(1)) : (rem_q == LENW'(1));
    end

    // State, counter, port select and output register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            last_q  <= last_d;
        end
    end

    // Next-state: grant capture, header length load, body countdown, abort.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rem_d   = rem_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_en) begin
                    state_d = ST_HDR;
                    sel_d   = i_sel;
                end
            end
            ST_HDR: begin
                if (!i_en) begin
                    state_d = ST_IDLE;
                end else if (pop) begin
                    rem_d   = len_eff - LENW'(1);
                    state_d = is_last ? ST_IDLE : ST_BODY;
                end
            end
            ST_BODY: begin
                if (!i_en) begin
                    state_d = ST_IDLE;
                end else if (pop) begin
                    rem_d   = rem_q - LENW'(1);
                    state_d = is_last ? ST_IDLE : ST_BODY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: pop strobe, status pulses, and output register load/hold/drain.
    always_comb begin
        o_pop   = '0;
        o_eop   = 1'b0;
        o_err   = 1'b0;
        valid_d = valid_q;
        data_d  = data_q;
        sop_d   = sop_q;
        last_d  = last_q;
        if (pop) begin
            o_pop[sel_q] = 1'b1;
            o_eop        = is_last;
            valid_d      = 1'b1;
            data_d       = mux_data;
            sop_d        = (state_q == ST_HDR);
            last_d       = is_last;
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
        if (active && !i_en) begin
            o_err = 1'b1;
        end else if (pop && (state_q == ST_HDR) && (mux_data[LENW-1:0] == '0)) begin
            o_err = 1'b1;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_sop   = sop_q;
    assign o_last  = last_q;

endmodule
